// File: rtl/rx_ctl_pkg.sv
// Shared constants for the UART receive path.
// RX_PARITY_EN selects 8E1 framing; otherwise 8N1.
package rx_ctl_pkg;

  localparam int DATA_W         = 8;
  localparam int OSR_DEF        = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

endpackage

// File: rtl/rx_ctl_mod.sv
// rxd synchroniser and deframing FSM.
// RX_PARITY_EN adds an even-parity bit before the stop bit.
module rx_mod
  import rx_ctl_pkg::*;
#(
  parameter int OSR = OSR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_byte,
  output logic              push,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int TW = $clog2(OSR);

  logic              s1, s2;
  logic [2:0]        st;
  logic [TW-1:0]     tick;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] sh;
  logic              mid, last;
  logic              stop_smp, perr;

  assign mid      = tick == TW'(OSR/2 - 1);
  assign last     = tick == TW'(OSR - 1);
  assign stop_smp = (st == S_STOP) && bclk && last;

`ifdef RX_PARITY_EN
  logic par_q;
  assign perr = stop_smp && (par_q != ^sh);
`else
  assign perr = 1'b0;
`endif

  assign push    = stop_smp && s2 && !perr;
  assign rx_byte = sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      st         <= S_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      s1         <= rxd;
      s2         <= s1;
      frame_err  <= stop_smp && !s2;
      parity_err <= perr;
      case (st)
        S_IDLE: if (!s2) begin
          st   <= S_START;
          tick <= '0;
        end
        S_START: if (bclk) begin
          if (mid) begin
            tick    <= '0;
            bit_cnt <= '0;
            st      <= s2 ? S_IDLE : S_DATA;
          end else tick <= tick + 1'b1;
        end
        S_DATA: if (bclk) begin
          if (last) begin
            tick    <= '0;
            sh      <= {s2, sh[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
`ifdef RX_PARITY_EN
            if (bit_cnt == 3'd7) st <= S_PARITY;
`else
            if (bit_cnt == 3'd7) st <= S_STOP;
`endif
          end else tick <= tick + 1'b1;
        end
        S_PARITY: begin
`ifdef RX_PARITY_EN
          if (bclk) begin
            if (last) begin
              tick  <= '0;
              par_q <= s2;
              st    <= S_STOP;
            end else tick <= tick + 1'b1;
          end
`else
          st <= S_IDLE;
`endif
        end
        S_STOP: if (bclk) begin
          if (last) begin
            tick <= '0;
            st   <= s2 ? S_IDLE : S_BREAK;
          end else tick <= tick + 1'b1;
        end
        // line held low after a bad stop: wait for idle before rearming
        S_BREAK: if (bclk && s2) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_ctl.sv
// UART receive controller: deframer, show-ahead FIFO, rts.
// Define RX_PARITY_EN for 8E1 framing with parity_err.
module rx_ctl
  import rx_ctl_pkg::*;
#(
  parameter int OSR        = OSR_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RTS_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              rxd,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              rx_vld,
  output logic              rts,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] rx_byte;
  logic              push;

  rx_mod #(.OSR(OSR)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .bclk       (bclk),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
    .push       (push),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp, rp, wp_nx, rp_nx, cnt_nx;
  logic              full, empty;
  logic              do_push, do_pop, ovr;

  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = rd && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign ovr     = push && full && !do_pop;
  assign wp_nx   = wp + {{AW{1'b0}}, do_push};
  assign rp_nx   = rp + {{AW{1'b0}}, do_pop};
  assign cnt_nx  = wp_nx - rp_nx;

  assign dout   = mem[rp[AW-1:0]];
  assign rx_vld = !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp      <= '0;
      rp      <= '0;
      rts     <= 1'b1;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp[AW-1:0]] <= rx_byte;
      wp      <= wp_nx;
      rp      <= rp_nx;
      overrun <= ovr;
      rts     <= cnt_nx <
                 (AW+1)'(FIFO_DEPTH - RTS_MARGIN);
    end
  end

endmodule

// File: tb/tb_rx_ctl.sv
// Directed bench for rx_ctl with a queue model of the FIFO.
// Define RX_PARITY_EN to also exercise 8E1 parity handling.
module tb_rx_ctl;

  logic       clk = 0, rst = 0, bclk = 0;
  logic       rxd = 1, rd = 0;
  logic [7:0] dout;
  logic       rx_vld, rts, frame_err, overrun, parity_err;

  rx_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .bclk       (bclk),
    .rxd        (rxd),
    .rd         (rd),
    .dout       (dout),
    .rx_vld     (rx_vld),
    .rts        (rts),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    int bk;
    bk = 0;
    forever begin
      @(negedge clk);
      bclk = (bk % 4 == 3);
      bk++;
    end
  end

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;
  logic [7:0] q[$];
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // model compare: FIFO head, not-empty and rts from occupancy
  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("rx_vld", rx_vld, q.size() != 0);
      if (q.size() != 0) chk("dout", dout, q[0]);
      chk("rts", rts, q.size() < 12);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  task automatic wait_ticks(int n);
    repeat (n) begin
      @(posedge clk);
      while (!bclk) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(logic [7:0] b, bit stop,
                            bit par_ok);
    chk_en = 0;
    rxd = 0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(16);
    end
`ifdef RX_PARITY_EN
    rxd = par_ok ? ^b : ~^b;
    wait_ticks(16);
`endif
    rxd = stop;
    wait_ticks(16);
    rxd = 1;
    wait_ticks(4);
    if (!stop) exp_fe++;
    else if (!par_ok) exp_pe++;
    else if (q.size() < 16) q.push_back(b);
    else exp_ov++;
    chk_en = 1;
  endtask

  task automatic pop_chk(logic [7:0] exp);
    @(negedge clk);
    chk("pop_vld", rx_vld, 1);
    chk("pop_dout", dout, exp);
    rd = 1;
    @(posedge clk);
    #1;
    rd = 0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_vld", rx_vld, 0);
    chk("rst_rts", rts, 1);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_pe", parity_err, 0);
    rst = 1;
    wait_ticks(4);
    chk_en = 1;

    // 1: single good byte
    send_frame(8'hA5, 1, 1);
    chk("t1_dout", dout, 8'hA5);
    chk("t1_vld", rx_vld, 1);
    pop_chk(8'hA5);
    chk("t1_fe", fe_cnt, 0);

    // 2: start glitch of 5 ticks
    chk_en = 0;
    rxd = 0;
    wait_ticks(5);
    rxd = 1;
    wait_ticks(20);
    chk_en = 1;
    chk("t2_vld", rx_vld, 0);
    chk("t2_fe", fe_cnt, 0);

    // 3: bad stop bit
    send_frame(8'h3C, 0, 1);
    wait_ticks(4);
    chk("t3_fe", fe_cnt, 1);
    chk("t3_vld", rx_vld, 0);

    // 4: fill past depth without reading
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1, 1);
      if (i == 10) chk("t4_rts11", rts, 1);
      if (i == 11) chk("t4_rts12", rts, 0);
    end
    chk("t4_ov", ov_cnt, 1);
    for (int i = 0; i < 16; i++) pop_chk(8'(i));
    chk("t4_empty", rx_vld, 0);
    chk("t4_rts", rts, 1);

    // 5: reset in the middle of a frame
    send_frame(8'hE7, 1, 1);
    chk_en = 0;
    rxd = 0;
    wait_ticks(16);
    rxd = 1;
    wait_ticks(16);
    rxd = 0;
    wait_ticks(8);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t5_dout", dout, 0);
    chk("t5_vld", rx_vld, 0);
    chk("t5_rts", rts, 1);
    q.delete();
    rxd = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    wait_ticks(4);
    chk_en = 1;
    send_frame(8'h81, 1, 1);
    pop_chk(8'h81);

`ifdef RX_PARITY_EN
    // 6: wrong then right parity
    send_frame(8'h07, 1, 0);
    chk("t6_pe", pe_cnt, 1);
    chk("t6_vld", rx_vld, 0);
    send_frame(8'h07, 1, 1);
    pop_chk(8'h07);
`endif

    wait_ticks(4);
    chk("fe_total", fe_cnt, exp_fe);
    chk("ov_total", ov_cnt, exp_ov);
    chk("pe_total", pe_cnt, exp_pe);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
